// File: rtl/filter_window_seq.sv
// Frame sequencer for the WINxWIN filter core: fetches each clamped neighbourhood, triggers the core, writes the result.
// Optional macro FILTER_WINDOW_REUSE_EN: within a row, shift the window and fetch only the new right column.
module filter_window_seq #(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 48,
    parameter int WIN    = 9,
    parameter int PIX_W  = 10,
    parameter int OP_LAT = 4,
    parameter int ADDR_W = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     rd_en,
    output logic [ADDR_W-1:0]        rd_addr,
    input  logic [PIX_W-1:0]         rd_data,
    output logic [WIN*WIN*PIX_W-1:0] data_bus,
    output logic                     refresh,
    input  logic [PIX_W-1:0]         op_out,
    output logic                     wr_en,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [PIX_W-1:0]         wr_data
);

    localparam int N_SLOT = WIN * WIN;
    localparam int H      = (WIN - 1) / 2;
    localparam int CNT_W  = $clog2(WIN);
    localparam int K_W    = $clog2(N_SLOT);
    localparam int LAT_W  = $clog2(OP_LAT + 1);
    localparam int CW     = ADDR_W + 1;

    localparam logic [CNT_W-1:0]  C_LAST   = CNT_W'(WIN - 1);
    localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(OP_LAT);
    localparam logic [ADDR_W-1:0] X_LAST   = ADDR_W'(IMG_W - 1);
    localparam logic [ADDR_W-1:0] Y_LAST   = ADDR_W'(IMG_H - 1);
    localparam logic [ADDR_W-1:0] IMG_W_A  = ADDR_W'(IMG_W);
    localparam logic [CW-1:0]     H_C      = CW'(H);
    localparam logic [CW-1:0]     XMAX_C   = CW'(IMG_W - 1);
    localparam logic [CW-1:0]     YMAX_C   = CW'(IMG_H - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DRAIN, S_REFRESH, S_WAIT, S_WRITE, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] x_q, x_d, y_q, y_d;
    logic [CNT_W-1:0]  r_q, r_d, c_q, c_d;
    logic              part_q, part_d;
    logic              pend_v_q, pend_v_d;
    logic [K_W-1:0]    pend_k_q, pend_k_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [PIX_W-1:0]  res_q, res_d;
    logic [PIX_W-1:0]  win_q [N_SLOT];
    logic [PIX_W-1:0]  win_d [N_SLOT];

    // Clamped source coordinate of the slot currently being fetched (edge replication).
    logic [CW-1:0]     sx_sum, sy_sum, sx, sy;
    logic [ADDR_W-1:0] src_addr, pix_addr;

    always_comb begin
        sx_sum = CW'(x_q) + CW'(c_q);
        sy_sum = CW'(y_q) + CW'(r_q);
        if (sx_sum < H_C)                 sx = '0;
        else if (sx_sum - H_C > XMAX_C)   sx = XMAX_C;
        else                              sx = sx_sum - H_C;
        if (sy_sum < H_C)                 sy = '0;
        else if (sy_sum - H_C > YMAX_C)   sy = YMAX_C;
        else                              sy = sy_sum - H_C;
        src_addr = ADDR_W'(sy) * IMG_W_A + ADDR_W'(sx);
        pix_addr = y_q * IMG_W_A + x_q;
    end

    always_comb begin
        data_bus = '0;
        for (int k = 0; k < N_SLOT; k++) data_bus[k*PIX_W +: PIX_W] = win_q[k];
    end

    // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        r_d      = r_q;
        c_d      = c_q;
        part_d   = part_q;
        pend_v_d = 1'b0;
        pend_k_d = pend_k_q;
        lat_d    = lat_q;
        res_d    = res_q;
        win_d    = win_q;
        busy     = (state_q != S_IDLE) && (state_q != S_DONE);
        done     = 1'b0;
        rd_en    = 1'b0;
        rd_addr  = '0;
        refresh  = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;

        // A read issued last cycle lands in its slot now (covers the DRAIN cycle too).
        if (pend_v_q) win_d[pend_k_q] = rd_data;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    x_d     = '0;
                    y_d     = '0;
                    r_d     = '0;
                    c_d     = '0;
                    part_d  = 1'b0;
                end
            end
            S_FETCH: begin
                rd_en    = 1'b1;
                rd_addr  = src_addr;
                pend_v_d = 1'b1;
                pend_k_d = K_W'(r_q) * K_W'(WIN) + K_W'(c_q);
                if (c_q == C_LAST) begin
                    c_d = part_q ? C_LAST : '0;
                    if (r_q == C_LAST) state_d = S_DRAIN;
                    else               r_d     = r_q + 1'b1;
                end else begin
                    c_d = c_q + 1'b1;
                end
            end
            S_DRAIN:   state_d = S_REFRESH;
            S_REFRESH: begin
                refresh = 1'b1;
                lat_d   = LAT_W'(1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (lat_q == LAT_LAST) begin
                    res_d   = op_out;
                    state_d = S_WRITE;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            S_WRITE: begin
                wr_en   = 1'b1;
                wr_addr = pix_addr;
                wr_data = res_q;
                state_d = S_FETCH;
                r_d     = '0;
                c_d     = '0;
                part_d  = 1'b0;
                if (x_q == X_LAST) begin
                    x_d = '0;
                    if (y_q == Y_LAST) state_d = S_DONE;
                    else               y_d     = y_q + 1'b1;
                end else begin
                    x_d = x_q + 1'b1;
`ifdef FILTER_WINDOW_REUSE_EN
                    part_d = 1'b1;
                    c_d    = C_LAST;
                    for (int r = 0; r < WIN; r++)
                        for (int c = 0; c < WIN - 1; c++)
                            win_d[r*WIN + c] = win_q[r*WIN + c + 1];
`endif
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: the window register file is reset as well, because data_bus must read 0 out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            r_q      <= '0;
            c_q      <= '0;
            part_q   <= 1'b0;
            pend_v_q <= 1'b0;
            pend_k_q <= '0;
            lat_q    <= '0;
            res_q    <= '0;
            for (int k = 0; k < N_SLOT; k++) win_q[k] <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            r_q      <= r_d;
            c_q      <= c_d;
            part_q   <= part_d;
            pend_v_q <= pend_v_d;
            pend_k_q <= pend_k_d;
            lat_q    <= lat_d;
            res_q    <= res_d;
            win_q    <= win_d;
        end
    end

endmodule

// File: tb/tb_filter_window_seq.sv
// Directed bench for filter_window_seq on a 4x3 frame, 3x3 window, core latency 2.
module tb_filter_window_seq;

    localparam int IMG_W  = 4;
    localparam int IMG_H  = 3;
    localparam int WIN    = 3;
    localparam int PIX_W  = 10;
    localparam int OP_LAT = 2;
    localparam int ADDR_W = 4;
    localparam int NPIX   = IMG_W * IMG_H;
    localparam int P_FULL = WIN * WIN + 3 + OP_LAT;
`ifdef FILTER_WINDOW_REUSE_EN
    localparam int P_ROW  = WIN + 3 + OP_LAT;
`else
    localparam int P_ROW  = P_FULL;
`endif

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     start = 1'b0;
    logic                     busy, done, rd_en, refresh, wr_en;
    logic [ADDR_W-1:0]        rd_addr, wr_addr;
    logic [PIX_W-1:0]         rd_data, op_out, wr_data;
    logic [WIN*WIN*PIX_W-1:0] data_bus;

    filter_window_seq #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .WIN(WIN),
        .PIX_W(PIX_W), .OP_LAT(OP_LAT), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .data_bus(data_bus), .refresh(refresh), .op_out(op_out),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Frame memory: pixel(addr) = addr, one cycle read latency, junk when not read.
    always @(posedge clk) rd_data <= rd_en ? PIX_W'(rd_addr) : 10'h2F0;

    // Core model: returns slot sel exactly OP_LAT cycles after refresh, junk otherwise.
    int         sel = 4;
    int         core_cnt = 0;
    logic [PIX_W-1:0] core_val = '0;
    always @(posedge clk) begin
        if (refresh) begin
            core_cnt <= 1;
            core_val <= data_bus[sel*PIX_W +: PIX_W];
        end else if (core_cnt != 0 && core_cnt < 15) begin
            core_cnt <= core_cnt + 1;
        end
    end
    assign op_out = (core_cnt == OP_LAT) ? core_val : 10'h3AA;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int first_rd, n_rd, n_wr, n_done, done_cyc, n_busy, n_ovl, n_bus_bad;
    int wa [64];
    int wd [64];
    int wt [64];
    logic [WIN*WIN*PIX_W-1:0] bus_ref;

    task automatic clear_stats();
        first_rd = -1; n_rd = 0; n_wr = 0; n_done = 0; done_cyc = 0;
        n_busy = 0; n_ovl = 0; n_bus_bad = 0; bus_ref = '0;
        for (int i = 0; i < 64; i++) begin wa[i] = 0; wd[i] = 0; wt[i] = 0; end
    endtask

    always @(negedge clk) begin
        if (rd_en) begin
            n_rd++;
            if (first_rd < 0) first_rd = cyc;
        end
        if (busy) n_busy++;
        if (refresh) bus_ref = data_bus;
        if (wr_en) begin
            if (n_wr < 64) begin wa[n_wr] = int'(wr_addr); wd[n_wr] = int'(wr_data); wt[n_wr] = cyc; end
            n_wr++;
            if (data_bus !== bus_ref) n_bus_bad++;
        end
        if (int'(rd_en) + int'(refresh) + int'(wr_en) > 1) n_ovl++;
        if (done) begin n_done++; done_cyc = cyc; end
    end

    function automatic int clampi(input int v, input int hi);
        return (v < 0) ? 0 : ((v > hi) ? hi : v);
    endfunction

    function automatic int exp_pix(input int x, input int y, input int s);
        int r, c;
        r = s / WIN;
        c = s % WIN;
        return clampi(y + r - 1, IMG_H - 1) * IMG_W + clampi(x + c - 1, IMG_W - 1);
    endfunction

    function automatic int period(input int x);
        return (x == 0) ? P_FULL : P_ROW;
    endfunction

    task automatic run_frame(input int s, input bit repulse);
        int tot;
        sel = s;
        clear_stats();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int i = 0; i < 3000 && n_done == 0; i++) begin
            @(negedge clk);
            start = repulse && (i == 20 || i == 100);
        end
        start = 1'b0;
        repeat (3) @(negedge clk);

        check($sformatf("s%0d done_count", s), n_done, 1);
        check($sformatf("s%0d n_writes", s), n_wr, NPIX);
        check($sformatf("s%0d first_wr_lat", s), wt[0] - first_rd, P_FULL - 1);
        tot = 1;
        for (int i = 0; i < NPIX; i++) begin
            tot += period(i % IMG_W);
            check($sformatf("s%0d wr_addr[%0d]", s, i), wa[i], i);
            check($sformatf("s%0d wr_data[%0d]", s, i), wd[i], exp_pix(i % IMG_W, i / IMG_W, s));
            if (i > 0) check($sformatf("s%0d wr_gap[%0d]", s, i), wt[i] - wt[i-1], period(i % IMG_W));
        end
        check($sformatf("s%0d done_after_wr", s), done_cyc - wt[NPIX-1], 1);
        check($sformatf("s%0d frame_len", s), done_cyc - first_rd + 1, tot);
        check($sformatf("s%0d busy_cycles", s), n_busy, tot - 1);
        check($sformatf("s%0d bus_stable", s), n_bus_bad, 0);
        check($sformatf("s%0d strobe_overlap", s), n_ovl, 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " busy"}, busy, 0);
        check({tag, " done"}, done, 0);
        check({tag, " rd_en"}, rd_en, 0);
        check({tag, " rd_addr"}, rd_addr, 0);
        check({tag, " refresh"}, refresh, 0);
        check({tag, " wr_en"}, wr_en, 0);
        check({tag, " wr_addr"}, wr_addr, 0);
        check({tag, " wr_data"}, wr_data, 0);
        check({tag, " bus_nonzero"}, data_bus != '0, 0);
    endtask

    initial begin
        clear_stats();
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("post_reset");

        // Centre slot: identity frame, with start re-pulsed while busy.
        run_frame(4, 1'b1);

        // Top-left slot: border replication.
        run_frame(0, 1'b0);
        check("border_00", wd[0], 0);
        check("border_32", wd[NPIX-1], 6);

        // Reset asserted mid-fetch.
        sel = 4;
        clear_stats();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_fetch rd_en", rd_en, 1);
        #2 rst = 1'b1;
        #1 check_idle_outputs("rst_async");
        @(negedge clk);
        check_idle_outputs("rst_held");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_stats();
        repeat (40) @(negedge clk);
        check("after_rst rd_count", n_rd, 0);
        check("after_rst wr_count", n_wr, 0);
        check("after_rst busy", busy, 0);

        // Recovery frame using the bottom-right slot.
        run_frame(8, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
